// File: rtl/wb_arb_pkg.sv
// Shared types, sizes and the round-robin pick function
// for the Wishbone arbiter family.
package wb_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  localparam int MAX_MASTERS = 8;
  localparam int IDXW = $clog2(MAX_MASTERS);
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  // First set bit strictly after last, wrapping; last itself ranks lowest.
  function automatic logic [IDXW-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [IDXW-1:0]        last
  );
    logic [IDXW-1:0] idx;
    rr_pick = last;
    for (int k = MAX_MASTERS; k >= 1; k--) begin
      idx = last + IDXW'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/wb_bus_if.sv
// Wishbone bus bundle with tags; master drives the request
// side, slave drives the response side.
interface wb_bus_t #(
  parameter int TAGSIZE = 2
);
  import wb_arb_pkg::*;

  logic [DW-1:0]      wb_dat_ms;
  logic [TAGSIZE-1:0] wb_tgd_ms;
  logic [AW-1:0]      wb_adr;
  logic [TAGSIZE-1:0] wb_tga;
  logic               wb_cyc;
  logic [TAGSIZE-1:0] wb_tgc;
  logic [SW-1:0]      wb_sel;
  logic               wb_stb;
  logic               wb_we;
  logic [DW-1:0]      wb_dat_sm;
  logic [TAGSIZE-1:0] wb_tgd_sm;
  logic               wb_ack;
  logic               wb_err;
  logic               wb_rty;

  modport master (
    output wb_dat_ms, wb_tgd_ms, wb_adr, wb_tga,
    output wb_cyc, wb_tgc, wb_sel, wb_stb, wb_we,
    input  wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_dat_ms, wb_tgd_ms, wb_adr, wb_tga,
    input  wb_cyc, wb_tgc, wb_sel, wb_stb, wb_we,
    output wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: next requester after
// last, as an index and as a one-hot vector (zero if none).
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx
);

  logic [MAX_MASTERS-1:0] req_ext;

  assign req_ext = MAX_MASTERS'(req);
  assign idx     = rr_pick(req_ext, last);

  for (genvar i = 0; i < N; i++) begin : g_oh
    assign onehot[i] = req[i] && (idx == IDXW'(i));
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter, N masters onto one slave.
// Define WB_ARB_TIMEOUT_EN to add the stalled-transfer watchdog.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TAGSIZE   = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  wb_bus_t.slave               wb_masters [N_MASTERS],
  wb_bus_t.master              wb_slave_bus,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic                 busy_o
);

  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS ||
      TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_arbiter: parameter out of range");
  end

  arb_state_e state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] pick_idx;
  logic [N_MASTERS-1:0] req, pick_oh, gnt;
  logic busy, to_hit;

  logic [DW-1:0]      m_dat [N_MASTERS];
  logic [TAGSIZE-1:0] m_tgd [N_MASTERS];
  logic [AW-1:0]      m_adr [N_MASTERS];
  logic [TAGSIZE-1:0] m_tga [N_MASTERS];
  logic [TAGSIZE-1:0] m_tgc [N_MASTERS];
  logic [SW-1:0]      m_sel [N_MASTERS];
  logic [N_MASTERS-1:0] m_stb, m_we;

  logic [DW-1:0]      s_dat;
  logic [TAGSIZE-1:0] s_tgd, s_tga, s_tgc;
  logic [AW-1:0]      s_adr;
  logic [SW-1:0]      s_sel;
  logic               s_cyc, s_stb, s_we;

  assign busy = (state_q == GRANT);

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
    assign req[i]   = wb_masters[i].wb_cyc;
    assign m_stb[i] = wb_masters[i].wb_stb;
    assign m_we[i]  = wb_masters[i].wb_we;
    assign m_dat[i] = wb_masters[i].wb_dat_ms;
    assign m_tgd[i] = wb_masters[i].wb_tgd_ms;
    assign m_adr[i] = wb_masters[i].wb_adr;
    assign m_tga[i] = wb_masters[i].wb_tga;
    assign m_tgc[i] = wb_masters[i].wb_tgc;
    assign m_sel[i] = wb_masters[i].wb_sel;

    assign gnt[i] = busy && (owner_q == IDXW'(i));

    assign wb_masters[i].wb_dat_sm =
      gnt[i] ? wb_slave_bus.wb_dat_sm : '0;
    assign wb_masters[i].wb_tgd_sm =
      gnt[i] ? wb_slave_bus.wb_tgd_sm : '0;
    assign wb_masters[i].wb_ack =
      gnt[i] & wb_slave_bus.wb_ack;
    assign wb_masters[i].wb_err =
      gnt[i] & (wb_slave_bus.wb_err | to_hit);
    assign wb_masters[i].wb_rty =
      gnt[i] & wb_slave_bus.wb_rty;
  end

  wb_rr_picker #(
    .N (N_MASTERS)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDXW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Ownership lasts for the whole cyc; stb gaps keep the lock.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          state_d = GRANT;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!s_cyc) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_dat = '0;
    s_tgd = '0;
    s_adr = '0;
    s_tga = '0;
    s_tgc = '0;
    s_sel = '0;
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) begin
        s_dat = m_dat[i];
        s_tgd = m_tgd[i];
        s_adr = m_adr[i];
        s_tga = m_tga[i];
        s_tgc = m_tgc[i];
        s_sel = m_sel[i];
        s_cyc = req[i];
        s_stb = m_stb[i];
        s_we  = m_we[i];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          resp;

  assign resp = wb_slave_bus.wb_ack |
                wb_slave_bus.wb_err |
                wb_slave_bus.wb_rty;
  assign to_hit = busy && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (!busy || !s_stb || resp || to_hit) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // The watchdog cycle withholds stb so the slave cannot
  // start a transfer that the owner already sees as failed.
  assign wb_slave_bus.wb_dat_ms = s_dat;
  assign wb_slave_bus.wb_tgd_ms = s_tgd;
  assign wb_slave_bus.wb_adr    = s_adr;
  assign wb_slave_bus.wb_tga    = s_tga;
  assign wb_slave_bus.wb_tgc    = s_tgc;
  assign wb_slave_bus.wb_sel    = s_sel;
  assign wb_slave_bus.wb_cyc    = s_cyc;
  assign wb_slave_bus.wb_stb    = s_stb & ~to_hit;
  assign wb_slave_bus.wb_we     = s_we;

  assign gnt_o  = gnt;
  assign busy_o = busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: four masters, scoreboard of expected
// (master, read data) pairs popped on every ack.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 4;
  localparam int TS = 2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ack_en;
  logic [NM-1:0] gnt;
  logic busy;

  logic [NM-1:0] m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [NM];
  logic [TS-1:0] m_tga [NM];
  logic [NM-1:0] m_ack, m_err, m_rty;
  logic [DW-1:0] m_dat [NM];
  logic [TS-1:0] m_tgd [NM];

  exp_t sb[$];
  int   glog[$];
  int   gcnt [NM];
  int   checks;
  int   errors;

  wb_bus_t #(.TAGSIZE(TS)) m_bus [NM] ();
  wb_bus_t #(.TAGSIZE(TS)) s_bus ();

  function automatic logic [DW-1:0] slv_dat(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  for (genvar g = 0; g < NM; g++) begin : g_m
    assign m_bus[g].wb_cyc    = m_cyc[g];
    assign m_bus[g].wb_stb    = m_stb[g];
    assign m_bus[g].wb_we     = m_we[g];
    assign m_bus[g].wb_adr    = m_adr[g];
    assign m_bus[g].wb_tga    = m_tga[g];
    assign m_bus[g].wb_tgc    = TS'(g);
    assign m_bus[g].wb_sel    = '1;
    assign m_bus[g].wb_dat_ms = 32'hD000_0000 + DW'(g);
    assign m_bus[g].wb_tgd_ms = TS'(g);
    assign m_ack[g] = m_bus[g].wb_ack;
    assign m_err[g] = m_bus[g].wb_err;
    assign m_rty[g] = m_bus[g].wb_rty;
    assign m_dat[g] = m_bus[g].wb_dat_sm;
    assign m_tgd[g] = m_bus[g].wb_tgd_sm;
  end

  assign s_bus.wb_ack    = s_bus.wb_cyc & s_bus.wb_stb & ack_en;
  assign s_bus.wb_err    = 1'b0;
  assign s_bus.wb_rty    = 1'b0;
  assign s_bus.wb_dat_sm = slv_dat(s_bus.wb_adr);
  assign s_bus.wb_tgd_sm = s_bus.wb_tga;

  wb_arbiter #(
    .N_MASTERS (NM),
    .TAGSIZE   (TS),
    .TIMEOUT   (8)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rst_n),
    .wb_masters   (m_bus),
    .wb_slave_bus (s_bus),
    .gnt_o        (gnt),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard pop on ack, quiet-bus and one-hot checks, grant log.
  initial begin
    logic [NM-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) begin
        if (m_ack[i] === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ack master %0d", i);
          end else begin
            e = sb.pop_front();
            if (e.idx !== i || m_dat[i] !== e.dat) begin
              errors++;
              $display("FAIL sb_ack got m%0d %h want m%0d %h",
                       i, m_dat[i], e.idx, e.dat);
            end
          end
        end
        if (!gnt[i] && (m_ack[i] || m_err[i] || m_rty[i] ||
                        m_dat[i] != '0 || m_tgd[i] != '0)) begin
          errors++;
          $display("FAIL quiet_bus master %0d ack=%b err=%b dat=%h",
                   i, m_ack[i], m_err[i], m_dat[i]);
        end
      end
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot got %b", gnt);
      end
      if (gnt != prev && gnt != '0) begin
        for (int i = 0; i < NM; i++) begin
          if (gnt[i]) begin
            glog.push_back(i);
            gcnt[i]++;
          end
        end
      end
      prev = gnt;
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    ack_en = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
    for (int i = 0; i < NM; i++) gcnt[i] = 0;
  endtask

  task automatic xfer(input int i, input logic [AW-1:0] a);
    int n;
    m_adr[i] = a;
    m_cyc[i] = 1'b1;
    m_stb[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_ack[i] !== 1'b1 && n < 100);
    checks++;
    if (m_ack[i] !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout master %0d ack=%b want 1", i, m_ack[i]);
    end
    @(posedge clk);
    #1;
    m_cyc[i] = 1'b0;
    m_stb[i] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_we[0]  = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got %b/%b want 0000/0", gnt, busy);
    end
    checks++;
    if ({s_bus.wb_cyc, s_bus.wb_stb, s_bus.wb_we} !== 3'b000 ||
        s_bus.wb_adr !== '0 || s_bus.wb_dat_ms !== '0 ||
        s_bus.wb_sel !== '0 || s_bus.wb_tgc !== '0 ||
        s_bus.wb_tgd_ms !== '0) begin
      errors++;
      $display("FAIL reset_slave got cyc=%b stb=%b we=%b adr=%h want 0",
               s_bus.wb_cyc, s_bus.wb_stb, s_bus.wb_we, s_bus.wb_adr);
    end
    checks++;
    if (m_ack !== '0 || m_err !== '0 || m_rty !== '0) begin
      errors++;
      $display("FAIL reset_resp got ack=%b err=%b want 0", m_ack, m_err);
    end
    m_we[0] = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h10;
    m_tga[0] = 2'd3;
    sb.push_back('{0, slv_dat(32'h10)});
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_c0_gnt got %b want 0000", gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt got %b/%b want 0001/1", gnt, busy);
    end
    checks++;
    if (s_bus.wb_adr !== 32'h10 || s_bus.wb_tga !== 2'd3) begin
      errors++;
      $display("FAIL single_adr got %h/%0d want 10/3",
               s_bus.wb_adr, s_bus.wb_tga);
    end
    checks++;
    if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_ack got m0=%b m1=%b want 1/0",
               m_ack[0], m_ack[1]);
    end
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || s_bus.wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %b/%b want 0000/0",
               gnt, s_bus.wb_cyc);
    end
  endtask

  task automatic test_handover();
    logic [NM-1:0] want [5];
    want = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    apply_reset();
    @(posedge clk);
    #1;
    m_adr[0] = 32'h20;
    m_adr[1] = 32'h24;
    m_cyc[1:0] = 2'b11;
    m_stb[1:0] = 2'b11;
    sb.push_back('{0, slv_dat(32'h20)});
    sb.push_back('{1, slv_dat(32'h24)});
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (gnt !== want[c]) begin
        errors++;
        $display("FAIL handover_c%0d got %b want %b", c, gnt, want[c]);
      end
    end
    checks++;
    if (m_ack[1] !== 1'b1) begin
      errors++;
      $display("FAIL handover_ack1 got %b want 1", m_ack[1]);
    end
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NM; i++)
        sb.push_back('{i, slv_dat(32'h100 + AW'(i * 16 + r))});
    @(posedge clk);
    #1;
    fork
      for (int r = 0; r < 4; r++) xfer(0, 32'h100 + AW'(r));
      for (int r = 0; r < 4; r++) xfer(1, 32'h110 + AW'(r));
      for (int r = 0; r < 4; r++) xfer(2, 32'h120 + AW'(r));
      for (int r = 0; r < 4; r++) xfer(3, 32'h130 + AW'(r));
    join
    checks++;
    if (glog.size() != 16) begin
      errors++;
      $display("FAIL fair_count got %0d grants want 16", glog.size());
    end
    for (int k = 0; k < glog.size(); k++) begin
      checks++;
      if (glog[k] != k % NM) begin
        errors++;
        $display("FAIL fair_order grant %0d got m%0d want m%0d",
                 k, glog[k], k % NM);
      end
    end
    for (int i = 0; i < NM; i++) begin
      checks++;
      if (gcnt[i] != 4) begin
        errors++;
        $display("FAIL fair_per_master m%0d got %0d want 4", i, gcnt[i]);
      end
    end
  endtask

  task automatic test_lock();
    int n;
    apply_reset();
    @(posedge clk);
    #1;
    m_adr[1] = 32'h40;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    sb.push_back('{1, slv_dat(32'h40)});
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL lock_first got %b want 0010", gnt);
    end
    @(posedge clk);
    #1;
    m_stb[1] = 1'b0;
    m_adr[0] = 32'h50;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || m_ack[0] !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold c%0d got %b ack0=%b want 0010/0",
                 c, gnt, m_ack[0]);
      end
    end
    @(posedge clk);
    #1;
    m_adr[1] = 32'h44;
    m_stb[1] = 1'b1;
    sb.push_back('{1, slv_dat(32'h44)});
    @(negedge clk);
    checks++;
    if (m_ack[1] !== 1'b1) begin
      errors++;
      $display("FAIL lock_resume got %b want 1", m_ack[1]);
    end
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    sb.push_back('{0, slv_dat(32'h50)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_ack[0] !== 1'b1 && n < 20);
    checks++;
    if (m_ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL lock_next got ack0=%b want 1", m_ack[0]);
    end
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    ack_en = 1'b0;
    @(posedge clk);
    #1;
    m_adr[2] = 32'h60;
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_owner got %b want 0100", gnt);
    end
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || s_bus.wb_cyc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort got gnt=%b cyc=%b busy=%b want 0",
               gnt, s_bus.wb_cyc, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_after got %b want 0001", gnt);
    end
    @(posedge clk);
    #1;
    m_cyc = '0;
    m_stb = '0;
    ack_en = 1'b1;
  endtask

  task automatic test_timeout();
    logic want_err, want_stb;
    apply_reset();
    ack_en = 1'b0;
    @(posedge clk);
    #1;
    m_adr[0] = 32'h70;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      want_err = TO_ON && (c == 9);
      want_stb = (c >= 1) && !want_err;
      checks++;
      if (m_err[0] !== want_err || s_bus.wb_stb !== want_stb) begin
        errors++;
        $display("FAIL timeout_c%0d got err=%b stb=%b want %b/%b",
                 c, m_err[0], s_bus.wb_stb, want_err, want_stb);
      end
    end
    @(posedge clk);
    #1;
    m_cyc = '0;
    m_stb = '0;
    ack_en = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ack_en = 1'b1;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    for (int i = 0; i < NM; i++) begin
      m_adr[i] = '0;
      m_tga[i] = '0;
      gcnt[i]  = 0;
    end
    test_reset();
    test_single();
    test_handover();
    test_fairness();
    test_lock();
    test_mid_reset();
    test_timeout();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
